// File: rtl/pulse_stretch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_stretch_pkg                                                          |
// | Shared state encodings and default timing constants for pulse_stretcher.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pulse_stretch_pkg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BLINK_MS = 100;
  localparam int DEFAULT_CYCLES = (CLK_FREQ / 1000) * BLINK_MS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_stretcher_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stretch_timer                                                              |
// | Loadable up-counter with an equality terminal-count output.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stretch_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] cmp,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  // Loading on terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign tc = (r_count == cmp);

endmodule
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_stretcher                                                            |
// | Stretches single-cycle events into fixed LED blinks with a guaranteed gap. |
// | Define PULSE_STRETCH_QUEUE_EN to queue events that arrive during a blink.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_CYCLES,
  parameter int OFF_CYCLES = DEFAULT_CYCLES,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              ovf_clr,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_count,
  output logic              ovf
);

  localparam int c_tmr_w = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
  localparam logic [c_tmr_w-1:0] c_on_last  = c_tmr_w'(ON_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_off_last = c_tmr_w'(OFF_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_led;
  logic                 r_ovf;
  logic                 w_tc;
  logic                 w_tmr_load;
  logic [c_tmr_w-1:0]   w_cmp;
  logic                 w_evt_busy;
  logic                 w_launch;
  logic                 w_drop;

  assign w_evt_busy = pulse_in && (r_state != S_IDLE);
  assign w_tmr_load = (r_state == S_IDLE) || w_tc;

  stretch_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_tmr_load),
    .cmp   (w_cmp),
    .tc    (w_tc)
  );

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] c_pend_max = '1;

  logic [PEND_W-1:0] r_pend;
  logic              w_pend_full;

  // A pulse on the OFF terminal cycle with nothing queued launches directly:
  // its increment cancels against the launch decrement, keeping IDLE at zero.
  assign w_launch    = (r_state == S_OFF) && w_tc && ((r_pend != '0) || pulse_in);
  assign w_pend_full = (r_pend == c_pend_max);
  assign w_drop      = w_evt_busy && !w_launch && w_pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (w_evt_busy && !w_launch && !w_pend_full) begin
      r_pend <= r_pend + PEND_W'(1);
    end else if (w_launch && !w_evt_busy) begin
      r_pend <= r_pend - PEND_W'(1);
    end
  end

  assign pend_count = r_pend;
`else
  assign w_launch   = 1'b0;
  assign w_drop     = w_evt_busy;
  assign pend_count = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cmp       = c_on_last;
    case (r_state)
      S_IDLE: begin
        if (pulse_in) w_state_nxt = S_ON;
      end
      S_ON: begin
        if (w_tc) w_state_nxt = S_OFF;
      end
      S_OFF: begin
        w_cmp = c_off_last;
        if (w_tc) w_state_nxt = w_launch ? S_ON : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_led   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= (w_state_nxt == S_ON);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign led_out = r_led;
  assign busy    = (r_state != S_IDLE);
  assign ovf     = r_ovf;

endmodule
`default_nettype wire
